// File: rtl/reg_writeback_sequencer.sv
// Writeback sequencer: buffers register writebacks in a small FIFO, drains
// one per cycle onto the register bank write port, and exposes a
// combinational lookup of pending (uncommitted) values for forwarding.
module reg_writeback_sequencer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       WB_VALID,
  output logic                       WB_READY,
  input  logic [ADDR_W-1:0]          WB_REG,
  input  logic [DATA_W-1:0]          WB_DATA,
  input  logic                       HOLD,
  input  logic [ADDR_W-1:0]          LOOKUP_REG,
  output logic                       LOOKUP_HIT,
  output logic [DATA_W-1:0]          LOOKUP_DATA,
  output logic                       REG_WRITE,
  output logic [ADDR_W-1:0]          WRITE_REGISTER,
  output logic [DATA_W-1:0]          WRITE_DATA,
  output logic [$clog2(DEPTH):0]     PENDING
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem_reg_q  [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q, rptr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q;
  logic [ADDR_W-1:0] wreg_q;
  logic [DATA_W-1:0] wdata_q;

  logic push, pop, lk_hit;
  logic [DATA_W-1:0] lk_data;

  // Ready depends only on registered occupancy, never on a same-cycle pop.
  // Writes to r0 are accepted but never enqueued (r0 is hardwired zero).
  always_comb begin
    WB_READY = !RST && (cnt_q < CNT_W'(DEPTH));
    push     = WB_VALID && WB_READY && (WB_REG != '0);
    pop      = (cnt_q != '0) && !HOLD;
    cnt_d    = cnt_q;
    if (push && !pop) cnt_d = cnt_q + CNT_W'(1);
    else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
  end

  // Pointers, occupancy and the write-port output stage.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      wr_q  <= pop;
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop) begin
        rptr_q  <= rptr_q + PTR_W'(1);
        wreg_q  <= mem_reg_q[rptr_q];
        wdata_q <= mem_data_q[rptr_q];
      end
    end
  end

  // FIFO storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_reg_q[wptr_q]  <= WB_REG;
      mem_data_q[wptr_q] <= WB_DATA;
    end
  end

  // Forwarding lookup: scan oldest to newest so the newest match wins;
  // the output stage is older than every FIFO entry.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    if (wr_q && (wreg_q == LOOKUP_REG)) begin
      lk_hit  = 1'b1;
      lk_data = wdata_q;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if ((CNT_W'(k) < cnt_q) && (mem_reg_q[rptr_q + PTR_W'(k)] == LOOKUP_REG)) begin
        lk_hit  = 1'b1;
        lk_data = mem_data_q[rptr_q + PTR_W'(k)];
      end
    end
    if (LOOKUP_REG == '0) begin
      lk_hit  = 1'b0;
      lk_data = '0;
    end
  end

  assign LOOKUP_HIT     = lk_hit;
  assign LOOKUP_DATA    = lk_data;
  assign REG_WRITE      = wr_q;
  assign WRITE_REGISTER = wreg_q;
  assign WRITE_DATA     = wdata_q;
  assign PENDING        = cnt_q;
endmodule
